// File: rtl/dt_cmp_pkg.sv
// Shared mode encodings and default widths for the decision-tree node comparator.
package dt_cmp_pkg;
  localparam int FEAT_W_DEF = 32;
  localparam int THR_W_DEF  = 27;
  localparam int LANES_DEF  = 4;
  localparam int TAG_W_DEF  = 8;

  typedef enum logic [1:0] {
    CMP_ULE = 2'b00,
    CMP_ULT = 2'b01,
    CMP_SLE = 2'b10,
    CMP_SLT = 2'b11
  } cmp_mode_e;

  function automatic logic mode_signed(input cmp_mode_e m);
    return (m == CMP_SLE) || (m == CMP_SLT);
  endfunction

  function automatic logic mode_strict(input cmp_mode_e m);
    return (m == CMP_ULT) || (m == CMP_SLT);
  endfunction
endpackage

// File: rtl/dt_lane_compare.sv
// One compare lane: widen the raw threshold to feature width, then apply the
// selected (un)signed <= / < relation.
module dt_lane_compare
  import dt_cmp_pkg::*;
#(
  parameter int FEAT_W = FEAT_W_DEF,
  parameter int THR_W  = THR_W_DEF
) (
  input  logic [FEAT_W-1:0] feature,
  input  logic [THR_W-1:0]  threshold,
  input  cmp_mode_e         mode,
  output logic              go_left
);
  logic [FEAT_W-1:0] thr_ext;
  logic              sgn, lt, eq;

  always_comb begin
    sgn     = mode_signed(mode);
    thr_ext = FEAT_W'(threshold);
    for (int b = THR_W; b < FEAT_W; b++) thr_ext[b] = sgn & threshold[THR_W-1];
    eq      = (feature == thr_ext);
    lt      = sgn ? ($signed(feature) < $signed(thr_ext)) : (feature < thr_ext);
    go_left = lt | (eq & ~mode_strict(mode));
  end
endmodule

// File: rtl/dt_node_comparator_pipe.sv
// Two-stage valid/ready pipeline: S1 holds operands, S2 holds per-lane results,
// their popcount and the tag.
module dt_node_comparator_pipe
  import dt_cmp_pkg::*;
#(
  parameter int FEAT_W = FEAT_W_DEF,
  parameter int THR_W  = THR_W_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*FEAT_W-1:0]    in_feature,
  input  logic [LANES*THR_W-1:0]     in_threshold,
  input  logic [1:0]                 in_mode,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES-1:0]           out_go_left,
  output logic [$clog2(LANES+1)-1:0] out_left_cnt,
  output logic [TAG_W-1:0]           out_tag
);
  localparam int CNT_W = $clog2(LANES+1);

  if (THR_W < 1 || THR_W > FEAT_W || LANES < 1) begin : g_bad_param
    $error("dt_node_comparator_pipe: illegal THR_W/FEAT_W/LANES combination");
  end

  logic [2:1]                    vld_pipe;
  logic [LANES-1:0][FEAT_W-1:0]  s1_feature;
  logic [LANES-1:0][THR_W-1:0]   s1_threshold;
  cmp_mode_e                     s1_mode;
  logic [TAG_W-1:0]              s1_tag;
  logic [LANES-1:0]              go_left;
  logic [CNT_W-1:0]              go_cnt;
  logic                          s2_ready, s1_adv, in_fire;

  // S2 can take a beat when empty or draining; S1 is ready under the same condition.
  assign s2_ready  = !vld_pipe[2] || out_ready;
  assign s1_adv    = vld_pipe[1] && s2_ready;
  assign in_ready  = !vld_pipe[1] || s2_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = vld_pipe[2];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dt_lane_compare #(.FEAT_W(FEAT_W), .THR_W(THR_W)) u_cmp (
      .feature   (s1_feature[i]),
      .threshold (s1_threshold[i]),
      .mode      (s1_mode),
      .go_left   (go_left[i])
    );
  end

  always_comb begin
    go_cnt = '0;
    for (int i = 0; i < LANES; i++) go_cnt = go_cnt + CNT_W'(go_left[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe     <= '0;
      s1_feature   <= '0;
      s1_threshold <= '0;
      s1_mode      <= CMP_ULE;
      s1_tag       <= '0;
      out_go_left  <= '0;
      out_left_cnt <= '0;
      out_tag      <= '0;
    end else begin
      if (in_ready) vld_pipe[1] <= in_valid;
      if (s2_ready) vld_pipe[2] <= vld_pipe[1];
      if (in_fire) begin
        s1_feature   <= in_feature;
        s1_threshold <= in_threshold;
        s1_mode      <= cmp_mode_e'(in_mode);
        s1_tag       <= in_tag;
      end
      if (s1_adv) begin
        out_go_left  <= go_left;
        out_left_cnt <= go_cnt;
        out_tag      <= s1_tag;
      end
    end
  end
endmodule

// File: tb/tb_dt_node_comparator_pipe.sv
// Bench for dt_node_comparator_pipe: directed corner beats, stall/reset scenarios
// and a randomized soak scored against an arithmetic reference model.
module tb_dt_node_comparator_pipe;
  localparam int L  = 4;
  localparam int FW = 32;
  localparam int TW = 27;
  localparam int GW = 8;
  localparam int CW = 3;

  typedef struct {
    logic [L-1:0]  go;
    logic [CW-1:0] cnt;
    logic [GW-1:0] tag;
  } exp_t;

  logic            clk = 0;
  logic            rst_n = 0;
  logic            in_valid = 0;
  logic            in_ready;
  logic [L*FW-1:0] in_feature = '0;
  logic [L*TW-1:0] in_threshold = '0;
  logic [1:0]      in_mode = '0;
  logic [GW-1:0]   in_tag = '0;
  logic            out_valid;
  logic            out_ready = 1;
  logic [L-1:0]    out_go_left;
  logic [CW-1:0]   out_left_cnt;
  logic [GW-1:0]   out_tag;

  int checks = 0;
  int errors = 0;

  dt_node_comparator_pipe #(.FEAT_W(FW), .THR_W(TW), .LANES(L), .TAG_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_feature(in_feature), .in_threshold(in_threshold), .in_mode(in_mode),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_go_left(out_go_left), .out_left_cnt(out_left_cnt), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Reference: interpret operands as integers and apply the relation directly.
  function automatic exp_t model(input logic [L*FW-1:0] f, input logic [L*TW-1:0] t,
                                 input logic [1:0] m, input logic [GW-1:0] tag);
    exp_t   e;
    longint fv, tv;
    e.cnt = '0;
    e.tag = tag;
    for (int i = 0; i < L; i++) begin
      fv = longint'(f[i*FW +: FW]);
      tv = longint'(t[i*TW +: TW]);
      if (m[1]) begin
        if (fv >= (64'sd1 <<< (FW-1))) fv = fv - (64'sd1 <<< FW);
        if (tv >= (64'sd1 <<< (TW-1))) tv = tv - (64'sd1 <<< TW);
      end
      e.go[i] = m[0] ? (fv < tv) : (fv <= tv);
      e.cnt   = e.cnt + CW'(e.go[i]);
    end
    return e;
  endfunction

  task automatic gen_beat(output logic [L*FW-1:0] f, output logic [L*TW-1:0] t,
                          output logic [1:0] m);
    logic [TW-1:0] th;
    logic [FW-1:0] ext;
    m = 2'($urandom_range(0, 3));
    for (int i = 0; i < L; i++) begin
      th  = TW'($urandom);
      ext = FW'(th);
      if (m[1] && th[TW-1]) ext = ext | ~((FW'(1) << TW) - FW'(1));
      t[i*TW +: TW] = th;
      if ($urandom_range(0, 2) == 0) f[i*FW +: FW] = ext + FW'($urandom_range(0, 2)) - FW'(1);
      else                           f[i*FW +: FW] = FW'($urandom);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Sends one beat into an empty pipe with out_ready=1 and captures what appears.
  task automatic run_beat(input logic [L*FW-1:0] f, input logic [L*TW-1:0] t,
                          input logic [1:0] m, input logic [GW-1:0] tag,
                          output logic v1, output logic v2, output logic [L-1:0] go,
                          output logic [CW-1:0] cnt, output logic [GW-1:0] otag);
    out_ready = 1; in_valid = 1; in_feature = f; in_threshold = t; in_mode = m; in_tag = tag;
    tick;
    in_valid = 0; in_feature = '1; in_mode = 2'($urandom);
    v1 = out_valid;
    tick;
    v2 = out_valid; go = out_go_left; cnt = out_left_cnt; otag = out_tag;
    tick;
  endtask

  task automatic test_reset;
    rst_n = 0; in_valid = 0; out_ready = 1;
    tick; tick;
    checks++;
    if (out_valid !== 1'b0 || out_go_left !== '0 || out_left_cnt !== '0 || out_tag !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b go=%b cnt=%0d tag=%0d, want all 0",
               out_valid, out_go_left, out_left_cnt, out_tag);
    end
    rst_n = 1; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    tick;
  endtask

  task automatic test_basic;
    logic [L*FW-1:0] f; logic [L*TW-1:0] t;
    logic v1, v2; logic [L-1:0] go; logic [CW-1:0] cnt; logic [GW-1:0] tg;
    f = {32'h0800_0000, 32'h07FF_FFFF, 32'd100, 32'd0};
    t = {4{27'h7FF_FFFF}};
    run_beat(f, t, 2'b00, 8'hA5, v1, v2, go, cnt, tg);
    checks++;
    if (v1 !== 1'b0 || v2 !== 1'b1) begin
      errors++; $display("FAIL basic_latency: valid c1=%b c2=%b want 0,1", v1, v2);
    end
    checks++;
    if (go !== 4'b0111 || cnt !== 3'd3 || tg !== 8'hA5) begin
      errors++; $display("FAIL basic_result: go=%b cnt=%0d tag=%h want 0111 3 a5", go, cnt, tg);
    end
  endtask

  task automatic test_equal;
    logic [L*FW-1:0] f; logic [L*TW-1:0] t;
    logic v1, v2; logic [L-1:0] go; logic [CW-1:0] cnt; logic [GW-1:0] tg;
    f = {4{32'd50}}; t = {4{27'd50}};
    run_beat(f, t, 2'b00, 8'h01, v1, v2, go, cnt, tg);
    checks++;
    if (v2 !== 1'b1 || go !== 4'b1111 || cnt !== 3'd4) begin
      errors++; $display("FAIL equal_ule: valid=%b go=%b cnt=%0d want 1 1111 4", v2, go, cnt);
    end
    run_beat(f, t, 2'b01, 8'h02, v1, v2, go, cnt, tg);
    checks++;
    if (v2 !== 1'b1 || go !== 4'b0000 || cnt !== 3'd0) begin
      errors++; $display("FAIL equal_ult: valid=%b go=%b cnt=%0d want 1 0000 0", v2, go, cnt);
    end
  endtask

  task automatic test_signed;
    logic [L*FW-1:0] f; logic [L*TW-1:0] t;
    logic v1, v2; logic [L-1:0] go; logic [CW-1:0] cnt; logic [GW-1:0] tg;
    f = {4{32'hFFFF_FFFE}}; t = {4{27'h7FF_FFFF}};
    run_beat(f, t, 2'b10, 8'h10, v1, v2, go, cnt, tg);
    checks++;
    if (go !== 4'b1111 || cnt !== 3'd4) begin
      errors++; $display("FAIL signed_sle: go=%b cnt=%0d want 1111 4", go, cnt);
    end
    run_beat(f, t, 2'b00, 8'h11, v1, v2, go, cnt, tg);
    checks++;
    if (go !== 4'b0000 || cnt !== 3'd0) begin
      errors++; $display("FAIL signed_as_ule: go=%b cnt=%0d want 0000 0", go, cnt);
    end
  endtask

  task automatic test_back_to_back;
    exp_t q[$]; exp_t e;
    logic [L*FW-1:0] f; logic [L*TW-1:0] t; logic [1:0] m;
    logic stall = 0; logic [L-1:0] pg = '0; logic [CW-1:0] pc = '0; logic [GW-1:0] pt = '0;
    int sent = 0, got = 0, cyc = 0;
    logic exp_rdy;
    gen_beat(f, t, m);
    while (got < 8 && cyc < 200) begin
      in_valid = (sent < 8); in_feature = f; in_threshold = t; in_mode = m; in_tag = GW'(sent);
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      #1;
      if (stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_go_left !== pg || out_left_cnt !== pc || out_tag !== pt) begin
          errors++; $display("FAIL b2b_stall_hold: valid=%b go=%b cnt=%0d tag=%0d want 1 %b %0d %0d",
                             out_valid, out_go_left, out_left_cnt, out_tag, pg, pc, pt);
        end
      end
      exp_rdy = !(q.size() == 2 && !out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL b2b_in_ready: cyc=%0d got %b want %b", cyc, in_ready, exp_rdy);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_beat: tag=%0d emitted with nothing pending", out_tag);
        end else begin
          e = q.pop_front();
          if (out_go_left !== e.go || out_left_cnt !== e.cnt || out_tag !== e.tag) begin
            errors++; $display("FAIL b2b_result: go=%b cnt=%0d tag=%0d want %b %0d %0d",
                               out_go_left, out_left_cnt, out_tag, e.go, e.cnt, e.tag);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(f, t, m, in_tag));
        sent++;
        gen_beat(f, t, m);
      end
      stall = out_valid && !out_ready; pg = out_go_left; pc = out_left_cnt; pt = out_tag;
      @(posedge clk); #1; cyc++;
    end
    in_valid = 0; out_ready = 1;
    checks++;
    if (got != 8 || q.size() != 0) begin
      errors++; $display("FAIL b2b_count: received %0d pending %0d want 8 0", got, q.size());
    end
    tick;
  endtask

  task automatic test_reset_mid;
    logic [L*FW-1:0] f; logic [L*TW-1:0] t; logic [1:0] m;
    out_ready = 0;
    for (int b = 0; b < 2; b++) begin
      gen_beat(f, t, m);
      in_valid = 1; in_feature = f; in_threshold = t; in_mode = m; in_tag = GW'(8'h40 + b);
      tick;
    end
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_setup: out_valid=%b want 1 before reset", out_valid);
    end
    rst_n = 0; #1;
    checks++;
    if (out_valid !== 1'b0 || out_go_left !== '0 || out_left_cnt !== '0 || out_tag !== '0) begin
      errors++; $display("FAIL rstmid_clear: valid=%b go=%b cnt=%0d tag=%0d want all 0",
                         out_valid, out_go_left, out_left_cnt, out_tag);
    end
    tick; tick;
    rst_n = 1; #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      tick;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL rstmid_stale: cycle %0d out_valid=%b want 0", c, out_valid);
      end
    end
  endtask

  task automatic test_soak;
    exp_t q[$]; exp_t e;
    logic [L*FW-1:0] f; logic [L*TW-1:0] t; logic [1:0] m;
    logic stall = 0; logic [L-1:0] pg = '0; logic [CW-1:0] pc = '0; logic [GW-1:0] pt = '0;
    int sent = 0, got = 0, cyc = 0;
    logic exp_rdy;
    while (got < 10000 && cyc < 60000) begin
      gen_beat(f, t, m);
      in_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
      in_feature = f; in_threshold = t; in_mode = m; in_tag = GW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_go_left !== pg || out_left_cnt !== pc || out_tag !== pt) begin
          errors++; $display("FAIL soak_stall_hold: cyc=%0d go=%b tag=%0d want %b %0d",
                             cyc, out_go_left, out_tag, pg, pt);
        end
      end
      exp_rdy = !(q.size() == 2 && !out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL soak_in_ready: cyc=%0d got %b want %b", cyc, in_ready, exp_rdy);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL soak_duplicate: cyc=%0d beat emitted with nothing pending", cyc);
        end else begin
          e = q.pop_front();
          if (out_go_left !== e.go || out_left_cnt !== e.cnt || out_tag !== e.tag) begin
            errors++; $display("FAIL soak_result: beat %0d go=%b cnt=%0d tag=%0d want %b %0d %0d",
                               got, out_go_left, out_left_cnt, out_tag, e.go, e.cnt, e.tag);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(f, t, m, in_tag));
        sent++;
      end
      stall = out_valid && !out_ready; pg = out_go_left; pc = out_left_cnt; pt = out_tag;
      @(posedge clk); #1; cyc++;
    end
    in_valid = 0;
    checks++;
    if (got != 10000 || q.size() != 0) begin
      errors++; $display("FAIL soak_count: received %0d pending %0d want 10000 0", got, q.size());
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_equal;
    test_signed;
    test_back_to_back;
    test_reset_mid;
    test_soak;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dt_node_comparator_pipe.md
DT_NODE_COMPARATOR_PIPE -- requirements
Module: dt_node_comparator_pipe

Interface
REQ-001 SHALL have parameter FEAT_W, default 32, feature lane width in bits.
REQ-002 SHALL have parameter THR_W, default 27, raw threshold width in bits, constrained to 1 <= THR_W <= FEAT_W.
REQ-003 SHALL have parameter LANES, default 4, number of parallel compare lanes, constrained to LANES >= 1.
REQ-004 SHALL have parameter TAG_W, default 8, sideband tag width.
REQ-005 SHALL have port clk  input  1  clock; all state is updated on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  input beat valid.
REQ-008 SHALL have port in_ready  output  1  block accepts the input beat.
REQ-009 SHALL have port in_feature  input  LANES*FEAT_W  packed features; lane i occupies bits [i*FEAT_W +: FEAT_W].
REQ-010 SHALL have port in_threshold  input  LANES*THR_W  packed raw thresholds; lane i occupies bits [i*THR_W +: THR_W].
REQ-011 SHALL have port in_mode  input  2  compare mode applying to all lanes of the beat.
REQ-012 SHALL have port in_tag  input  TAG_W  opaque tag, e.g. node index.
REQ-013 SHALL have port out_valid  output  1  result beat valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the result beat.
REQ-015 SHALL have port out_go_left  output  LANES  per-lane compare result.
REQ-016 SHALL have port out_left_cnt  output  $clog2(LANES+1)  popcount of out_go_left.
REQ-017 SHALL have port out_tag  output  TAG_W  tag of the result beat.

Function
REQ-018 SHALL decode in_mode as follows: 00 unsigned <=, 01 unsigned <, 10 signed <=, 11 signed <.
REQ-019 SHALL extend each threshold to FEAT_W bits: zero-extended for unsigned modes, sign-extended from bit THR_W-1 for signed modes.
REQ-020 SHALL set out_go_left[i] to 1 when feature_i compared to the extended threshold_i satisfies the selected relation; with in_mode=00 this reproduces the legacy single-lane behaviour.
REQ-021 SHALL complete a beat transfer on a cycle with in_valid && in_ready, and a result transfer on a cycle with out_valid && out_ready.
REQ-022 SHALL be a 2-stage pipeline: S1 registers operands, mode and tag; S2 registers the compare results, the popcount and the tag.
REQ-023 SHALL present an accepted beat on out_valid exactly 2 cycles after acceptance when there are no stalls.
REQ-024 SHALL sustain throughput of 1 beat per cycle while out_ready=1.
REQ-025 SHALL advance a stage only if it is empty or its downstream stage advances in the same cycle; in_ready SHALL equal !S1_valid || S1 advancing.
REQ-026 SHALL hold out_go_left, out_left_cnt and out_tag stable while out_valid=1 && out_ready=0.
REQ-027 SHALL neither drop nor duplicate beats under any in_valid/out_ready pattern, and SHALL preserve beat order.
REQ-028 SHALL NOT require in_valid to be held once it is asserted, and SHALL ignore in_feature, in_threshold, in_mode and in_tag when in_valid=0.
REQ-029 SHALL hold no combinational path from in_valid, in_feature, in_threshold or in_mode to any output; in_ready MAY depend combinationally on out_ready.

Reset
REQ-030 SHALL drive out_valid=0, out_go_left=0, out_left_cnt=0, out_tag=0 and both stage-valid flags to 0 while rst_n=0.
REQ-031 SHALL drive in_ready=1 during the first cycle after rst_n deasserts.
REQ-032 SHALL discard in-flight beats without emitting any output when reset is asserted mid-operation.

Structure
REQ-033 SHALL take from package dt_cmp_pkg: the mode encodings (CMP_ULE, CMP_ULT, CMP_SLE, CMP_SLT) and the default width constants.
REQ-034 SHALL instantiate sub-module dt_lane_compare (combinational; one feature, one threshold and the mode in, one go_left bit out) LANES times via generate.
REQ-035 SHALL implement the popcount and the pipeline control in the top module.

Verification
REQ-036 SHALL cover: LANES=4, mode 00, features {0,100,0x07FFFFFF,0x08000000}, all thresholds 0x07FFFFFF -> out_go_left=4'b0111, out_left_cnt=3, out_valid asserted 2 cycles after acceptance.
REQ-037 SHALL cover: feature equal to threshold (50 vs 50) in mode 00 -> go_left=1; in mode 01 -> go_left=0.
REQ-038 SHALL cover: mode 10, THR_W=27, threshold 0x7FFFFFF (= -1), feature 0xFFFFFFFE (= -2) -> go_left=1; the same beat in mode 00 -> go_left=0.
REQ-039 SHALL cover: 8 back-to-back beats with tags 0..7 and out_ready toggling 1,0,0,1,... -> all 8 beats emitted in order, outputs stable while stalled, in_ready=0 only when both stages are full.
REQ-040 SHALL cover: rst_n asserted with 2 beats in flight -> out_valid=0 immediately, no stale beat after release, in_ready=1 in the first cycle after release.
REQ-041 SHALL cover: a random 10k-beat soak with random valid/ready against a reference model -> zero mismatches, drops or duplicates.
